// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO.
// Frames are streamed back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLKS_PER_BAUD = 104,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        din,
    input  logic                        valid,
    output logic                        ready,
    output logic                        uart,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BAUD);
    localparam int BW = 4;

    localparam logic [CW-1:0] RELOAD    = CW'(CLKS_PER_BAUD - 1);
    localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);
    localparam logic          HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t state, state_n;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par, par_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic                 push, pop, tick, empty;

    assign ready = (level != FULL);
    assign empty = (level == '0);
    assign push  = valid & ready;
    assign head  = mem[rd_ptr];
    assign tick  = (cnt == '0);
    assign busy  = (state != S_IDLE) | ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
            if (valid & ~ready) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            par     <= par_n;
        end
    end

    // Every bit period ends on tick; the timer reloads on any transition.
    always_comb begin
        state_n = state;
        cnt_n   = tick ? RELOAD : cnt - CW'(1);
        bit_n   = bit_idx;
        shreg_n = shreg;
        par_n   = par;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_n = RELOAD;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    par_n   = (^head) ^ ODD;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    bit_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    if (bit_idx == LAST_DATA) begin
                        bit_n   = '0;
                        state_n = HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        bit_n = bit_idx + BW'(1);
                    end
                end
            end
            S_PAR: begin
                if (tick) begin
                    bit_n   = '0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_idx != LAST_STOP) begin
                        bit_n = bit_idx + BW'(1);
                    end else if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = head;
                        par_n   = (^head) ^ ODD;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        uart = 1'b1;
        unique case (state)
            S_START: uart = 1'b0;
            S_DATA:  uart = shreg[0];
            S_PAR:   uart = par;
            default: uart = 1'b1;
        endcase
    end

endmodule
